cntr_cla_n: RTL

- Parametrised synchronous loadable up/down counter; the next generation of the 8-bit CLA-based counter.
- The count datapath is a WIDTH-bit carry-lookahead adder built from 4-bit CLA groups (ripple between groups), adding +STEP or -STEP (two's complement) to the count register.
- A 4-state FSM selects load, increment, decrement or hold each cycle.
- Adds step size, decrement, terminal-count flag and overflow/underflow pulse, none of which the 8-bit counter has.

---
 rtl/cntr_cla_n_if.sv | 22 ++
 rtl/cntr_cla_n.sv | 67 ++++++
 2 files changed

// File: rtl/cntr_cla_n_if.sv
// cntr_cla_n_if: control/data bundle for the CLA up/down counter
interface cntr_cla_n_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic             inc;
  logic             dec;
  logic             sat;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic [1:0]       o_state;
  logic             tc;
  logic             ovf;
  modport master (
    output load, inc, dec, sat, d_in,
    input  d_out, o_state, tc, ovf
  );
  modport slave (
    input  load, inc, dec, sat, d_in,
    output d_out, o_state, tc, ovf
  );
endinterface

// File: rtl/cntr_cla_n.sv
// cntr_cla_n: loadable up/down counter on a 4-bit-group CLA adder; CNTR_SAT_EN enables clamping via sat
module cntr_cla_n #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input logic         clk,
  input logic         reset,
  cntr_cla_n_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, INC = 2'b10, DEC = 2'b11} state_t;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, operand, sum;
  logic             ovf_q, cin, carry, boundary;
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] p, g;
    logic [4:0] c;
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & ci);
    return {c[4], p ^ c[3:0]};
  endfunction
  always_comb begin
    state_d = bus.load ? LOAD : (bus.inc & ~bus.dec) ? INC : (bus.dec & ~bus.inc) ? DEC : IDLE;
  end
  assign cin     = (state_d == DEC);
  assign operand = cin ? ~STEP_W : STEP_W;
  // groups are lookahead internally, carry ripples group to group
  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < WIDTH / 4; i++) begin
      {carry, sum[4*i +: 4]} = cla4(cnt_q[4*i +: 4], operand[4*i +: 4], carry);
    end
  end
  // carry out on INC is overflow, missing carry on DEC is a borrow
  assign boundary = ((state_d == INC) & carry) | ((state_d == DEC) & ~carry);
  always_comb begin
    cnt_d = (state_d == LOAD) ? bus.d_in : (state_d == IDLE) ? cnt_q : sum;
`ifdef CNTR_SAT_EN
    if (bus.sat & boundary) cnt_d = (state_d == INC) ? '1 : '0;
`endif
  end
`ifndef CNTR_SAT_EN
  logic unused_sat;
  assign unused_sat = bus.sat;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= boundary;
    end
  end
  assign bus.d_out   = cnt_q;
  assign bus.o_state = state_q;
  assign bus.ovf     = ovf_q;
  assign bus.tc      = ((state_q == INC) & (&cnt_q)) | ((state_q == DEC) & ~(|cnt_q));
endmodule
